// File: rtl/seg_ctrl_pkg.sv
// rtl/seg_ctrl_pkg.sv - shared constants, bus FSM states and hex font for the 7-segment controller
package seg_ctrl_pkg;

    localparam logic [2:0] ADDR_DIGIT3 = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_BRIGHT = 3'd5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_HEX    = 1;
    localparam int CTRL_BLINK  = 2;

    localparam logic [2:0] CTRL_RESET   = 3'b001;
    localparam logic [3:0] BRIGHT_RESET = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } bus_state_t;

    // Segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - digit scan, PWM phase and blink phase counters
module seg_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx,
    output logic [3:0] phase,
    output logic       blink_ph
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_DIV + 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [SW-1:0] scan_cnt;
    logic [FW-1:0] frame_cnt;

    // Cascaded counters: slot cycles -> digit index -> frames -> blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (idx == IDX_LAST) begin
                idx <= '0;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // PWM phase is the top nibble of the slot counter, so every slot has 16 duty steps
    assign phase = scan_cnt[SW-1 -: 4];

endmodule

// File: rtl/seg_display_controller.sv
// rtl/seg_display_controller.sv - I2C-byte register front end and multiplexed 7-segment driver
module seg_display_controller
    import seg_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLINK_DIV  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_start,
    input  logic                  rx_stop,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  tx_ack,
    output logic [7:0]            tx_data,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en
);

    bus_state_t state;
    bus_state_t next_state;
    logic [2:0] ptr;
    logic [7:0] shadow [4];
    logic [7:0] active [4];
    logic [2:0] ctrl;
    logic [3:0] bright;
    logic       addr_load;
    logic       data_wr;
    logic [1:0] idx;
    logic [3:0] phase;
    logic       blink_ph;
    logic       lit;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .phase    (phase),
        .blink_ph (blink_ph)
    );

    // Bus FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // START always re-enters ADDR and outranks everything; STOP ends the transaction
    always_comb begin
        next_state = state;
        if (rx_start)                          next_state = ST_ADDR;
        else if (rx_stop)                      next_state = ST_IDLE;
        else if (state == ST_ADDR && rx_valid) next_state = ST_DATA;
    end

    // A byte arriving alongside START or STOP is dropped
    always_comb begin
        addr_load = (state == ST_ADDR) && rx_valid && !rx_start && !rx_stop;
        data_wr   = (state == ST_DATA) && rx_valid && !rx_start && !rx_stop;
    end

    // Register file: pointer, shadow digits, control; STOP commits shadow to active
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            ctrl   <= CTRL_RESET;
            bright <= BRIGHT_RESET;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (addr_load)              ptr <= rx_data[2:0];
            else if (data_wr || tx_ack) ptr <= ptr + 3'd1;

            if (data_wr) begin
                if (ptr <= ADDR_DIGIT3)       shadow[ptr[1:0]] <= rx_data;
                else if (ptr == ADDR_CTRL)    ctrl   <= rx_data[2:0];
                else if (ptr == ADDR_BRIGHT)  bright <= rx_data[3:0];
            end

            if (rx_stop) begin
                for (int i = 0; i < 4; i++) active[i] <= shadow[i];
            end
        end
    end

    // Read data follows the pointer; unmapped bits and addresses read as zero
    always_comb begin
        tx_data = 8'h00;
        if (!ptr[2])                 tx_data = shadow[ptr[1:0]];
        else if (ptr == ADDR_CTRL)   tx_data = {5'b0, ctrl};
        else if (ptr == ADDR_BRIGHT) tx_data = {4'b0, bright};
    end

    assign lit = (phase <= bright);

    // Registered segment/digit drive with enable, blink and PWM gating
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out <= '0;
            dig_en  <= '0;
        end else if (!ctrl[CTRL_ENABLE] || (ctrl[CTRL_BLINK] && blink_ph) || !lit) begin
            seg_out <= '0;
            dig_en  <= '0;
        end else begin
            dig_en  <= NUM_DIGITS'(1) << idx;
            seg_out <= ctrl[CTRL_HEX] ? {active[idx][7], hex7(active[idx][3:0])} : active[idx];
        end
    end

endmodule

// File: tb/tb_seg_display_controller.sv
// tb/tb_seg_display_controller.sv - self-checking bench for seg_display_controller
module tb_seg_display_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_start = 1'b0;
    logic       rx_stop = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_ack = 1'b0;
    logic [7:0] tx_data;
    logic [7:0] seg_out;
    logic [3:0] dig_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_controller #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (16),
        .BLINK_DIV  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_start (rx_start),
        .rx_stop  (rx_stop),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_ack   (tx_ack),
        .tx_data  (tx_data),
        .seg_out  (seg_out),
        .dig_en   (dig_en)
    );

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
    } disp_t;

    logic [7:0]  m_active [4];
    logic [2:0]  m_ctrl;
    logic [3:0]  m_bright;
    logic        chk_en = 1'b0;
    int unsigned bn = 0;
    disp_t       disp_q [$];
    logic [7:0]  tx_q [$];

    // Expected drive computed from absolute cycle count since reset
    function automatic disp_t expect_disp(input int unsigned n);
        int unsigned scan = n % 16;
        int unsigned di   = (n / 16) % 4;
        logic        ph   = ((n / 128) % 2) == 1;
        disp_t       d    = '0;
        if (m_ctrl[0] && !(m_ctrl[2] && ph) && scan <= m_bright) begin
            d.dig = 4'b0001 << di;
            d.seg = m_ctrl[1] ? {m_active[di][7], HEX[m_active[di][3:0]]} : m_active[di];
        end
        return d;
    endfunction

    always @(posedge clk) begin
        if (rst) bn <= 0;
        else     bn <= bn + 1;
    end

    always @(posedge clk) begin
        if (chk_en && !rst) disp_q.push_back(expect_disp(bn));
    end

    always @(negedge clk) begin
        disp_t e;
        if (disp_q.size() > 0) begin
            e = disp_q.pop_front();
            checks++;
            if ({seg_out, dig_en} !== e) begin
                errors++;
                $display("FAIL display t=%0t: got seg=%h dig=%b, expected seg=%h dig=%b",
                         $time, seg_out, dig_en, e.seg, e.dig);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic bus_start();
        rx_start = 1'b1;
        tick(1);
        rx_start = 1'b0;
    endtask

    task automatic bus_stop();
        rx_stop = 1'b1;
        tick(1);
        rx_stop = 1'b0;
    endtask

    task automatic watch(input int n);
        chk_en = 1'b1;
        tick(n);
        chk_en = 1'b0;
        tick(1);
    endtask

    task automatic read_byte(output logic [7:0] v);
        v      = tx_data;
        tx_ack = 1'b1;
        tick(1);
        tx_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] exp_tbl [8];
        logic [7:0] got;
        logic [7:0] e;
        exp_tbl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h00};
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_active[i] = 8'h00;
        m_ctrl   = 3'b001;
        m_bright = 4'hF;
        checks++;
        if (seg_out !== 8'h00 || dig_en !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got seg=%h dig=%b, expected 00/0000", seg_out, dig_en);
        end
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(exp_tbl[i]);
            read_byte(got);
            e = tx_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h expected %h", i, got, e);
            end
        end
        watch(70);
    endtask

    task automatic test_full_duty();
        bus_start();
        put(8'h00); put(8'h12); put(8'h34); put(8'h56); put(8'h78);
        bus_stop();
        m_active[0] = 8'h12; m_active[1] = 8'h34; m_active[2] = 8'h56; m_active[3] = 8'h78;
        watch(80);
    endtask

    task automatic test_abort();
        bus_start();
        put(8'h00); put(8'h11); put(8'h22);
        bus_start();
        watch(40);
        bus_stop();
        m_active[0] = 8'h11; m_active[1] = 8'h22;
        watch(70);
    endtask

    task automatic test_hex_bright();
        bus_start();
        put(8'h04); put(8'h03); put(8'h02);
        bus_stop();
        bus_start();
        put(8'h00); put(8'h8A);
        bus_stop();
        m_ctrl = 3'b011; m_bright = 4'h2; m_active[0] = 8'h8A;
        watch(70);
    endtask

    task automatic test_wrap();
        logic [7:0] exp_tbl [8];
        logic [7:0] got;
        logic [7:0] e;
        exp_tbl = '{8'h00, 8'hCC, 8'h22, 8'h56, 8'h78, 8'h03, 8'h02, 8'h00};
        bus_start();
        put(8'h06); put(8'hAA); put(8'hBB); put(8'hCC);
        bus_stop();
        m_active[0] = 8'hCC;
        watch(70);
        bus_start();
        put(8'h07);
        bus_stop();
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(exp_tbl[i]);
            read_byte(got);
            e = tx_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL wrap_read[%0d]: got %h expected %h", i, got, e);
            end
        end
        bus_start();
        put(8'h05); put(8'hF7);
        bus_stop();
        bus_start();
        put(8'h05);
        bus_stop();
        m_bright = 4'h7;
        tx_q.push_back(8'h07);
        read_byte(got);
        e = tx_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL bright_upper_dropped: got %h expected %h", got, e);
        end
    endtask

    task automatic test_blink();
        bus_start();
        put(8'h04); put(8'h05); put(8'h0F);
        bus_stop();
        m_ctrl = 3'b101; m_bright = 4'hF;
        watch(300);
        bus_start();
        put(8'h04); put(8'h00);
        bus_stop();
        m_ctrl = 3'b000;
        watch(40);
    endtask

    task automatic test_coincident();
        logic [7:0] exp_tbl [3];
        logic [7:0] got;
        logic [7:0] e;
        exp_tbl = '{8'h78, 8'h00, 8'h22};
        bus_start();
        put(8'h01);
        rx_start = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        tick(1);
        rx_start = 1'b0;
        rx_valid = 1'b0;
        put(8'h03);
        bus_stop();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus_start();
                put(8'h01);
                bus_stop();
            end
            tx_q.push_back(exp_tbl[i]);
            read_byte(got);
            e = tx_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL coincident_read[%0d]: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_data();
        bus_start();
        put(8'h00); put(8'h99);
        test_reset();
    endtask

    initial begin
        test_reset();
        test_full_duty();
        test_abort();
        test_hex_bright();
        test_wrap();
        test_blink();
        test_coincident();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
